// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and default sizing for the memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam int DEF_LOAD_WAIT   = 2;
  localparam int DEF_STORE_WAIT  = 2;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_ACK_TIMEOUT = 15;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Control-side bundle between decode, the sequencer and the memory-bus wrapper.
interface mem_access_sequencer_if;

  logic halt;
  logic load_en;
  logic store_en;
  logic mem_ack;
  logic instr_read_en;
  logic data_read_en;
  logic data_write_en;
  logic data_done;
  logic busy;
  logic timeout_err;
  logic req_conflict;

  modport master (
    output halt, load_en, store_en, mem_ack,
    input  instr_read_en, data_read_en, data_write_en, data_done, busy,
           timeout_err, req_conflict
  );

  modport slave (
    input  halt, load_en, store_en, mem_ack,
    output instr_read_en, data_read_en, data_write_en, data_done, busy,
           timeout_err, req_conflict
  );

endinterface

// File: rtl/mem_access_sequencer_wait_counter.sv
// Loadable down-counter that stops at zero; zero marks the last wait-state cycle.
module wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences data-memory loads/stores against instruction fetch on the shared port,
// with per-type wait states and an optional acknowledge with timeout.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int LOAD_WAIT   = DEF_LOAD_WAIT,
  parameter int STORE_WAIT  = DEF_STORE_WAIT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int USE_ACK     = 0,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst,
  mem_access_sequencer_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             active;
  logic             show;
  logic             start_load;
  logic             start_store;
  logic             ack_ok;
  logic             timed_out;
  logic             finish;

  wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (active && !bus.halt),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Reset forces IDLE-looking outputs so an aborted access never emits data_done.
  always_comb begin
    active       = (state == LOAD) || (state == STORE);
    show         = active && !rst;
    start_load   = (state == IDLE) && !bus.halt && bus.load_en;
    start_store  = (state == IDLE) && !bus.halt && bus.store_en && !bus.load_en;
    ack_ok       = (USE_ACK == 0) || bus.mem_ack;
    timed_out    = (USE_ACK != 0) && active && !bus.halt && cnt_zero && !bus.mem_ack &&
                   (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));
    finish       = active && !bus.halt && cnt_zero && (ack_ok || timed_out);
    cnt_load     = start_load || start_store;
    cnt_load_val = start_load ? CNT_W'(LOAD_WAIT - 1) : CNT_W'(STORE_WAIT - 1);

    bus.instr_read_en = !show && !bus.halt && !bus.load_en && !bus.store_en;
    bus.data_read_en  = show && (state == LOAD);
    bus.data_write_en = show && (state == STORE);
    bus.busy          = show;
    bus.data_done     = show && finish;
    bus.timeout_err   = show && timed_out;
    bus.req_conflict  = !show && !bus.halt && bus.load_en && bus.store_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_load) begin
            state <= LOAD;
          end else if (start_store) begin
            state <= STORE;
          end
        end
        LOAD, STORE: begin
          if (finish) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if ((USE_ACK != 0) && !bus.halt && cnt_zero) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Parametrised successor to the core's fixed two-cycle load/store fetch-stall controller.
- Sequences data-memory accesses against instruction fetch on the shared memory port:
  - gates instr_read_en while a load or store is in flight;
  - drives separate data read and write strobes;
  - supports independent configurable load and store wait states;
  - optionally waits for a memory acknowledge, with a timeout.
- Sits between the decode/control unit (halt, load_en, store_en) and the memory-bus wrapper.

Parameters:
- LOAD_WAIT, 2: cycles spent in LOAD state; legal range 1..2**CNT_W-1.
- STORE_WAIT, 2: cycles spent in STORE state; legal range 1..2**CNT_W-1.
- CNT_W, 4: width of the wait-state counter.
- USE_ACK, 0: 0 = fixed latency, mem_ack ignored; 1 = completion also requires mem_ack.
- ACK_TIMEOUT, 15: USE_ACK=1 only; maximum cycles to wait for mem_ack once the wait count expires; must be ≥1 and fit in CNT_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  pipeline halt; blocks new accesses and freezes an in-flight one.
- load_en  in  1  load request from decode, level, sampled in IDLE only.
- store_en  in  1  store request from decode, level, sampled in IDLE only.
- mem_ack  in  1  memory acknowledge; used only when USE_ACK=1.
- instr_read_en  out  1  instruction fetch enable.
- data_read_en  out  1  data read strobe, high throughout LOAD.
- data_write_en  out  1  data write strobe, high throughout STORE.
- data_done  out  1  one-cycle pulse on the final cycle of an access.
- busy  out  1  high in LOAD or STORE.
- timeout_err  out  1  one-cycle pulse, coincident with data_done, when the ack timed out.
- req_conflict  out  1  one-cycle pulse when load_en and store_en are both accepted in the same cycle.

Behaviour:
- Reset:
  - Clock is clk; reset rst is synchronous and active-high.
  - While rst=1 at a rising edge: state←IDLE, wait counter←0, timeout counter←0.
  - All outputs are combinational from state, counters and inputs; in IDLE with no request, instr_read_en=1 and all others 0.
  - rst mid-access aborts the access with no data_done pulse.
- IDLE:
  - halt=1: instr_read_en=0, no transition, requests ignored.
  - halt=0, no request: instr_read_en=1.
  - halt=0, load_en=1: instr_read_en=0 this cycle; next state LOAD; wait counter←LOAD_WAIT-1.
  - halt=0, store_en=1 only: same as load, but next state STORE and counter←STORE_WAIT-1.
  - Both load_en and store_en high: load wins; req_conflict=1 for that cycle.
- LOAD / STORE:
  - instr_read_en=0; busy=1; data_read_en (LOAD) or data_write_en (STORE) =1.
  - halt=1: counters frozen, state held, strobes remain asserted.
  - halt=0 and counter>0: counter decrements.
  - halt=0, counter=0, USE_ACK=0: data_done=1; next state IDLE.
  - halt=0, counter=0, USE_ACK=1, mem_ack=1: data_done=1; next state IDLE; timeout counter←0.
  - halt=0, counter=0, USE_ACK=1, mem_ack=0: timeout counter increments.
  - Timeout counter reaching ACK_TIMEOUT-1 with no ack: data_done=1, timeout_err=1; next state IDLE.
- Latency: with USE_ACK=0 and no halt, instr_read_en is low for exactly 1+WAIT cycles per access. With the defaults this is 3 cycles, matching the legacy controller.
- Requests are not latched outside IDLE; load_en/store_en during LOAD/STORE are ignored. Decode holds its request until data_done.
- Back-to-back: the cycle after data_done is IDLE, so a held request restarts immediately and instr_read_en is low continuously.
- Illegal or unreachable state encoding: next state IDLE, outputs as IDLE.
- mem_ack outside the counter=0 window is ignored.

Decomposition:
- Shared package mem_seq_pkg:
  - state_t enum {IDLE, LOAD, STORE}, 2 bits;
  - default wait-state and timeout localparams.
- Sub-module wait_counter:
  - loadable down-counter with load, enable (=!halt), zero flag;
  - parametrised by CNT_W;
  - instantiated once.
- The timeout counter is inline.

Test Plan:
- Defaults, 1-cycle load_en pulse in IDLE → instr_read_en low 3 cycles; data_read_en high cycles 2–3; data_done at cycle 3; IDLE at cycle 4.
- LOAD_WAIT=4, STORE_WAIT=1, store_en → instr_read_en low 2 cycles, data_write_en 1 cycle; then load_en → low 5 cycles, data_done on 5th.
- Defaults, halt high 2 cycles during LOAD with counter=1 → access stretched to 5 low cycles, data_done once; halt in IDLE with load_en → instr_read_en=0, no transition.
- USE_ACK=1, ACK_TIMEOUT=3: mem_ack 1 cycle after count expiry → data_done then; mem_ack never → data_done and timeout_err together on 3rd waiting cycle.
- load_en=store_en=1 in IDLE → LOAD entered, req_conflict single pulse, data_write_en never asserted.
- rst=1 in cycle 2 of STORE → next cycle IDLE, instr_read_en=1, no data_done; outputs as IDLE throughout rst.
